// File: rtl/dreg_seq.sv
// Command sequencer fronting the 32-entry data register file: read, masked write,
// dump (streamed run of registers) and reserved-op error response.
module dreg_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [4:0]       cmd_addr,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_addr,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic [4:0]       rf_ra,
  input  logic [WIDTH-1:0] rf_rval,
  output logic             rf_w,
  output logic [4:0]       rf_wa,
  output logic [WIDTH-1:0] rf_wval,
  output logic [WIDTH-1:0] rf_mask
);

  typedef enum logic [2:0] {IDLE, RD, WR, RSP, DRD, DRSP} state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q;
  logic [WIDTH-1:0] wdata_q, wmask_q;
  logic [4:0]       rsp_addr_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_last_q, rsp_err_q;
  logic             accept;

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        case (cmd_op)
          2'b00:   state_d = RD;
          2'b01:   state_d = WR;
          2'b10:   state_d = DRD;
          default: state_d = RSP;
        endcase
      end
      RD:   state_d = RSP;
      WR:   state_d = IDLE;
      RSP:  if (rsp_ready) state_d = IDLE;
      DRD:  state_d = DRSP;
      DRSP: if (rsp_ready) state_d = (idx_q == 5'd31) ? IDLE : DRD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RSP) || (state_q == DRSP);
    rf_w      = (state_q == WR);
  end

  // Response fields only move on accept (reserved op) or in RD/DRD, so they hold while valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= cmd_addr;
        wdata_q <= cmd_data;
        wmask_q <= cmd_mask;
        if (cmd_op == 2'b11) begin
          rsp_addr_q <= cmd_addr;
          rsp_data_q <= '0;
          rsp_last_q <= 1'b1;
          rsp_err_q  <= 1'b1;
        end
      end
      if (state_q == RD || state_q == DRD) begin
        rsp_addr_q <= idx_q;
        rsp_data_q <= rf_rval;
        rsp_last_q <= (state_q == RD) || (idx_q == 5'd31);
        rsp_err_q  <= 1'b0;
      end
      if (state_q == DRSP && rsp_ready && idx_q != 5'd31)
        idx_q <= idx_q + 5'd1;
    end
  end

  assign rsp_addr = rsp_addr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_last = rsp_last_q;
  assign rsp_err  = rsp_err_q;
  assign rf_ra    = idx_q;
  assign rf_wa    = idx_q;
  assign rf_wval  = wdata_q;
  assign rf_mask  = wmask_q;

endmodule

// File: tb/tb_dreg_seq.sv
// Scoreboarded bench for dreg_seq: a behavioural register-file model predicts every
// response beat and write pulse; a monitor compares them as the DUT presents them.
module tb_dreg_seq;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        last;
    logic        err;
  } beat_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] m;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last, rsp_err;
  logic [4:0]  rf_ra, rf_wa;
  logic [31:0] rf_rval, rf_wval, rf_mask;
  logic        rf_w;

  dreg_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rf_ra(rf_ra), .rf_rval(rf_rval), .rf_w(rf_w), .rf_wa(rf_wa),
    .rf_wval(rf_wval), .rf_mask(rf_mask)
  );

  always #5 clk = ~clk;

  // Register file the sequencer drives: masked merge, low half mirrored to upper half.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  assign rf_rval = rf_mem[rf_ra];
  always @(posedge clk) begin
    if (rf_w) begin
      rf_mem[rf_wa] <= (rf_mem[rf_wa] & ~rf_mask) | (rf_wval & rf_mask);
      if (rf_wa < 5'd16)
        rf_mem[rf_wa + 5'd16] <= (rf_mem[rf_wa + 5'd16] & ~rf_mask) | (rf_wval & rf_mask);
    end
  end

  logic [31:0] ref_mem [32] = '{default: 32'h0};
  beat_t exp_q[$];
  wr_t   wq[$];
  int    tests = 0;
  int    errs = 0;
  int    cyc = 0;
  int    last_hs = -10;
  int    rmode = 2;
  int    pcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // rsp_ready policy: 0 random, 1 pattern 1,0,0,..., 2 always high, 3 stall any beat at addr 30
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: rsp_ready = 1'($urandom_range(0, 1));
      1: begin rsp_ready = (pcnt % 3 == 0); pcnt++; end
      2: rsp_ready = 1'b1;
      default: rsp_ready = !(rsp_valid && rsp_addr == 5'd30);
    endcase
  end

  // Monitor: handshakes pop the beat queue; stalled beats must hold; write pulses pop wq.
  beat_t held;
  logic  hold_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (hold_v)
          check("rsp_stable", {25'd0, rsp_addr, rsp_data, rsp_last, rsp_err},
                {25'd0, held.a, held.d, held.last, held.err});
        if (rsp_ready) begin
          hold_v = 1'b0;
          if (rsp_last) last_hs = cyc + 1;
          if (exp_q.size() == 0) begin
            tests++; errs++;
            $display("FAIL unexpected_beat: got addr %0d data %h", rsp_addr, rsp_data);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("rsp_beat", {25'd0, rsp_addr, rsp_data, rsp_last, rsp_err},
                  {25'd0, e.a, e.d, e.last, e.err});
          end
        end else begin
          hold_v = 1'b1;
          held = '{rsp_addr, rsp_data, rsp_last, rsp_err};
        end
      end else hold_v = 1'b0;
      if (rf_w) begin
        if (wq.size() == 0) begin
          tests++; errs++;
          $display("FAIL unexpected_rf_w: got addr %0d data %h", rf_wa, rf_wval);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("rf_write", {27'd0, rf_wa, rf_wval}, {27'd0, w.a, w.d});
          check("rf_mask", {32'd0, rf_mask}, {32'd0, w.m});
        end
      end
    end
  end

  function automatic void model_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
    ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
    if (a < 5'd16) ref_mem[a + 5'd16] = (ref_mem[a + 5'd16] & ~m) | (d & m);
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d,
                          input logic [31:0] m, input bit apply, output int acc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      tests++; errs++;
      $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1");
      cmd_valid = 1'b0; acc = -1;
      return;
    end
    acc = cyc + 1;
    case (op)
      2'b00: exp_q.push_back('{a, ref_mem[a], 1'b1, 1'b0});
      2'b01: begin
        wq.push_back('{a, d, m});
        if (apply) model_write(a, d, m);
      end
      2'b10: for (int i = int'(a); i < 32; i++)
        exp_q.push_back('{5'(i), ref_mem[i], i == 31, 1'b0});
      default: exp_q.push_back('{a, 32'h0, 1'b1, 1'b1});
    endcase
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 5'($urandom); cmd_data = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      tests++; errs++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int acc, acc2, n;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rf_w", 64'(rf_w), 64'd0);
    check("rst_rf_regs", {22'd0, rf_ra, rf_wa, rf_wval}, 64'd0);
    check("rst_rf_mask", 64'(rf_mask), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // read latency on a zeroed file
    rmode = 2;
    send_cmd(2'b00, 5'd5, 32'h0, 32'h0, 1'b1, acc);
    @(negedge clk); check("rd_lat_early", 64'(rsp_valid), 64'd0);
    @(negedge clk); check("rd_lat", 64'(rsp_valid), 64'd1);
    drain();

    // masked write with mirror, single-cycle rf_w
    send_cmd(2'b01, 5'd3, 32'hDEADBEEF, 32'hFFFF0000, 1'b1, acc);
    @(negedge clk);
    check("wr_rf_w_hi", 64'(rf_w), 64'd1);
    check("wr_cmd_ready_lo", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("wr_rf_w_lo", 64'(rf_w), 64'd0);
    check("wr_cmd_ready_hi", 64'(cmd_ready), 64'd1);
    send_cmd(2'b00, 5'd3, 32'h0, 32'h0, 1'b1, acc);
    send_cmd(2'b00, 5'd19, 32'h0, 32'h0, 1'b1, acc);
    drain();

    // dump from 28 with stalling consumer
    rmode = 1; pcnt = 0;
    send_cmd(2'b10, 5'd28, 32'h0, 32'h0, 1'b1, acc);
    drain();
    @(negedge clk); check("dump_idle", 64'(cmd_ready), 64'd1);

    // reserved op
    rmode = 0;
    send_cmd(2'b11, 5'd7, 32'h0, 32'h0, 1'b1, acc);
    drain();

    // command held during a dump is taken in the first IDLE cycle
    send_cmd(2'b10, 5'd20, 32'h0, 32'h0, 1'b1, acc);
    send_cmd(2'b00, 5'd9, 32'h0, 32'h0, 1'b1, acc2);
    check("held_cmd_accept", 64'(acc2), 64'(last_hs + 1));
    drain();

    // reset while a dump beat at idx 30 is stalled
    rmode = 3;
    send_cmd(2'b10, 5'd28, 32'h0, 32'h0, 1'b1, acc);
    n = 0;
    while (!(rsp_valid && rsp_addr == 5'd30) && n < 200) begin @(negedge clk); n++; end
    check("reach_idx30", 64'(rsp_valid && rsp_addr == 5'd30), 64'd1);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("rst_mid_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid_rf_w", 64'(rf_w), 64'd0);
    exp_q.delete(); wq.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    rmode = 0;
    send_cmd(2'b00, 5'd30, 32'h0, 32'h0, 1'b1, acc);
    drain();

    // reset during the write cycle drops the write
    send_cmd(2'b01, 5'd4, 32'h12345678, 32'hFFFFFFFF, 1'b0, acc);
    rst = 1'b1; #1;
    check("rst_wr_drop", 64'(rf_w), 64'd0);
    wq.delete();
    @(negedge clk); rst = 1'b0;
    send_cmd(2'b00, 5'd4, 32'h0, 32'h0, 1'b1, acc);
    send_cmd(2'b00, 5'd20, 32'h0, 32'h0, 1'b1, acc);
    drain();

    // randomized mix
    for (int k = 0; k < 60; k++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10 && $urandom_range(0, 2) != 0) op = 2'b01;
      send_cmd(op, 5'($urandom), $urandom, $urandom, 1'b1, acc);
    end
    drain();
    repeat (4) @(negedge clk);
    check("wr_queue_empty", 64'(wq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
